// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the UART transmit path.
//   tx_state_t : frame sequencing states of uart_tx_ctrl.
//   SEL_*      : TX output multiplexer select codes. These are shared with the
//                mux, so the encodings must not change.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_STOP  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: payload latch and bit sequencer for uart_tx_ctrl.
// Ports:
//   clk, rst_n : bit-rate clock, asynchronous active-low reset
//   load       : capture p_data (controller accepting a word)
//   start      : present bit 0 on the next edge (controller in START)
//   step       : advance to the next bit (controller in DATA)
//   p_data     : parallel payload
//   s_data     : registered serial bit, 1 whenever no data bit is presented
//   done       : the last data bit is currently on s_data
module uart_tx_serializer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  start,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] p_data,
  output logic                  s_data,
  output logic                  done
);

  localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_nxt;

  // cnt_q is the index of the bit currently driven on s_data, so s_data is
  // registered with the bit that cnt_q will point at after the edge.
  assign cnt_nxt = cnt_q + CNT_W'(1);
  assign done    = (cnt_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      s_data <= 1'b1;
    end else if (load) begin
      data_q <= p_data;
      cnt_q  <= '0;
      s_data <= 1'b1;
    end else if (start) begin
      cnt_q  <= '0;
      s_data <= data_q[0];
    end else if (step && !done) begin
      cnt_q  <= cnt_nxt;
      s_data <= data_q[cnt_nxt];
    end else begin
      cnt_q  <= '0;
      s_data <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmitter control/datapath stage feeding the TX mux.
// Sends one frame per accepted word, one bit per CLK: start, data LSB first,
// optional parity, stop.
// Ports:
//   CLK, RST   : bit-rate clock, asynchronous active-low reset
//   P_DATA     : payload, sampled on acceptance
//   DATA_VALID : send request, honoured only in IDLE
//   PAR_EN     : append parity bit (sampled on acceptance)
//   PAR_TYP    : 0 even, 1 odd (sampled on acceptance)
//   SEL        : mux select (00 start, 01 stop/idle, 10 data, 11 parity)
//   S_DATA     : current serial data bit
//   PAR        : parity of the latched word
//   BUSY       : frame in progress
// Build option: define UART_TX_PARITY_EN to include parity generation and the
// PARITY state; otherwise PAR_EN/PAR_TYP are ignored and PAR is 0.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            SEL,
  output logic                  S_DATA,
  output logic                  PAR,
  output logic                  BUSY
);

  tx_state_t state;
  logic      accept;
  logic      done;
  logic      use_parity;

  assign accept = (state == IDLE) && DATA_VALID;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk   (CLK),
    .rst_n (RST),
    .load  (accept),
    .start (state == START),
    .step  (state == DATA),
    .p_data(P_DATA),
    .s_data(S_DATA),
    .done  (done)
  );

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_q;

  // Parity is computed from P_DATA at acceptance so PAR is already valid
  // during START and stays fixed for the whole frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else if (accept) begin
      par_en_q <= PAR_EN;
      par_q    <= (^P_DATA) ^ PAR_TYP;
    end
  end

  assign PAR        = par_q;
  assign use_parity = par_en_q;
`else
  logic unused_par_cfg;
  assign unused_par_cfg = PAR_EN ^ PAR_TYP;
  assign PAR            = 1'b0;
  assign use_parity     = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      SEL   <= SEL_STOP;
      BUSY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (DATA_VALID) begin
            state <= START;
            SEL   <= SEL_START;
            BUSY  <= 1'b1;
          end
        end
        START: begin
          state <= DATA;
          SEL   <= SEL_DATA;
        end
        DATA: begin
          if (done) begin
            if (use_parity) begin
              state <= PARITY;
              SEL   <= SEL_PAR;
            end else begin
              state <= STOP;
              SEL   <= SEL_STOP;
            end
          end
        end
        PARITY: begin
          state <= STOP;
          SEL   <= SEL_STOP;
        end
        STOP: begin
          state <= IDLE;
          SEL   <= SEL_STOP;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          SEL   <= SEL_STOP;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
